// File: rtl/bc_clr_skid_buf.sv
// bc_clr_skid_buf: two-entry valid/ready skid buffer with synchronous flush.
// Feeds the clear/enable data register stage: oDat/oVld/iClr become its
// iDat/iEn/iClr. Every output is a flop, so there is no combinational path
// from iRdy to oRdy.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-low reset
//   iClr  - synchronous flush: drops buffered beats, reloads INI_DATA
//   iVld  - upstream valid        oRdy - upstream ready
//   iDat  - upstream data         oDat - downstream data (main register)
//   iRdy  - downstream ready      oVld - downstream valid
//   oCnt  - occupancy, 0..2
module bc_clr_skid_buf #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] mainNext;
  logic [WIDTH-1:0] skidNext;
  logic             upXfer;
  logic             downXfer;

  // Handshakes use the registered flags, which are decodes of the current state.
  assign upXfer   = iVld & oRdy;
  assign downXfer = oVld & iRdy;

  // Next-state and data-path selection.
  always_comb begin
    stateNext = state;
    mainNext  = oDat;
    skidNext  = skid;
    if (iClr) begin
      // Flush voids any handshake in the same cycle.
      stateNext = EMPTY;
      mainNext  = INI_DATA;
      skidNext  = INI_DATA;
    end else begin
      unique case (state)
        EMPTY: begin
          if (iVld) begin
            mainNext  = iDat;
            stateNext = ONE;
          end
        end
        ONE: begin
          if (upXfer && downXfer) begin
            mainNext = iDat;
          end else if (upXfer) begin
            skidNext  = iDat;
            stateNext = FULL;
          end else if (downXfer) begin
            // main keeps its stale value so oDat never goes unknown.
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (iRdy) begin
            mainNext  = skid;
            stateNext = ONE;
          end
        end
        default: begin
          stateNext = EMPTY;
        end
      endcase
    end
  end

  // State, data and output flags; flags are loaded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      oDat  <= INI_DATA;
      skid  <= INI_DATA;
      oVld  <= 1'b0;
      oRdy  <= 1'b1;
      oCnt  <= 2'd0;
    end else begin
      state <= stateNext;
      oDat  <= mainNext;
      skid  <= skidNext;
      oVld  <= (stateNext != EMPTY);
      oRdy  <= (stateNext != FULL);
      oCnt  <= 2'(stateNext);
    end
  end

endmodule

// File: tb/tb_bc_clr_skid_buf.sv
// Self-checking bench for bc_clr_skid_buf: directed vector table, streaming,
// and randomized traffic against a queue-based reference model.
module tb_bc_clr_skid_buf;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] INI = 32'h1;

  logic         clk = 1'b0;
  logic         rst;
  logic         iClr;
  logic         iVld;
  logic         oRdy;
  logic [W-1:0] iDat;
  logic         oVld;
  logic         iRdy;
  logic [W-1:0] oDat;
  logic [1:0]   oCnt;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  bc_clr_skid_buf #(.WIDTH(W), .INI_DATA(INI)) dut (
    .clk (clk),
    .rst (rst),
    .iClr(iClr),
    .iVld(iVld),
    .oRdy(oRdy),
    .iDat(iDat),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat),
    .oCnt(oCnt)
  );

  typedef struct {
    logic         rst;
    logic         clr;
    logic         vld;
    logic         rdy;
    logic [W-1:0] dat;
    logic         eVld;
    logic         eRdy;
    logic [1:0]   eCnt;
    logic [W-1:0] eDat;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic v, input logic rd,
                       input logic [W-1:0] d);
    rst = r; iClr = c; iVld = v; iRdy = rd; iDat = d;
  endtask

  // Advance one edge, then sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAll(input string name, input logic v, input logic r,
                        input logic [1:0] c, input logic [W-1:0] d);
    chk({name, ".oVld"}, W'(oVld), W'(v));
    chk({name, ".oRdy"}, W'(oRdy), W'(r));
    chk({name, ".oCnt"}, W'(oCnt), W'(c));
    chk({name, ".oDat"}, oDat, d);
  endtask

  // Reference model state: queued beats with the head on oDat.
  logic [W-1:0] mq[$];
  logic [W-1:0] mLast;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // rst clr vld rdy dat        eVld eRdy eCnt eDat
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b1,2'd0,INI,   "rst0"});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,32'hEE, 1'b0,1'b1,2'd0,INI,   "rst1"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hB0, 1'b1,1'b1,2'd1,32'hB0,"bpB0"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hB1, 1'b1,1'b0,2'd2,32'hB0,"bpB1"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hB2, 1'b1,1'b0,2'd2,32'hB0,"bpHold"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b1,32'hB2, 1'b1,1'b1,2'd1,32'hB1,"bpOutB1"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hB2, 1'b1,1'b0,2'd2,32'hB1,"bpB2"});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,32'h0,  1'b1,1'b1,2'd1,32'hB2,"bpOutB2"});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b1,2'd0,32'hB2,"drain"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hE0, 1'b1,1'b1,2'd1,32'hE0,"fillE0"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hE1, 1'b1,1'b0,2'd2,32'hE0,"fillE1"});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,32'hE2, 1'b0,1'b1,2'd0,INI,   "flushFull"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hC4, 1'b1,1'b1,2'd1,32'hC4,"oneC4"});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b1,32'hC5, 1'b0,1'b1,2'd0,INI,   "flushXfer"});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b1,2'd0,INI,   "noC5"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hD0, 1'b1,1'b1,2'd1,32'hD0,"fillD0"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hDF, 1'b1,1'b0,2'd2,32'hD0,"fillDF"});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b1,2'd0,INI,   "rstFull"});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,32'hD1, 1'b1,1'b1,2'd1,32'hD1,"postRstD1"});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b1,2'd0,32'hD1,"drainD1"});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].rdy, vecs[i].dat);
      tick();
      chkAll(vecs[i].name, vecs[i].eVld, vecs[i].eRdy, vecs[i].eCnt, vecs[i].eDat);
    end

    // Streaming: one beat per cycle, each visible right after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hA0 + W'(i));
      tick();
      chkAll($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'hA0 + W'(i));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chkAll("streamEnd", 1'b0, 1'b1, 2'd0, 32'hA7);

    // Random traffic against the queue model, starting from reset.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    mq.delete();
    mLast = INI;
    chkAll("rndRst", 1'b0, 1'b1, 2'd0, INI);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic         c, v, r, stall, up, down;
      logic [W-1:0] d, prevDat;
      c = ($urandom_range(99) < 2);
      v = 1'($urandom);
      r = 1'($urandom);
      d = W'($urandom);
      stall   = (mq.size() > 0) && !r;
      prevDat = oDat;
      drive(1'b1, c, v, r, d);
      tick();
      if (c) begin
        mq.delete();
        mLast = INI;
      end else begin
        up   = v && (mq.size() < 2);
        down = (mq.size() > 0) && r;
        if (down) void'(mq.pop_front());
        if (up) mq.push_back(d);
        if (mq.size() > 0) mLast = mq[0];
      end
      chkAll($sformatf("rnd%0d", cyc), mq.size() > 0, mq.size() < 2,
             2'(mq.size()), mLast);
      if (stall && !c) begin
        chk($sformatf("rndStallDat%0d", cyc), oDat, prevDat);
        chk($sformatf("rndStallVld%0d", cyc), W'(oVld), W'(1'b1));
      end
      if (oCnt == 2'd2) chk($sformatf("rndRdyFull%0d", cyc), W'(oRdy), W'(1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/bc_clr_skid_buf.md
Name: bc_clr_skid_buf

Overview:
- Two-entry valid/ready register slice (skid buffer) with synchronous flush. It sits directly upstream of the clear/enable random-init data register stage.
- Its registered output data, its valid flag and its flush are what that stage consumes as iDat, iEn and iClr.
- It breaks the combinational ready path between producer and consumer.
- Data registers return to INI_DATA on reset or flush, matching the downstream register's init value.

Parameters:
- WIDTH, 32, data width in bits.
- INI_DATA, {WIDTH{1'b0}}, value loaded into both data registers on reset and on iClr.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; reset is synchronous and active-low.
- iClr  input  1  synchronous flush: empties the buffer and loads INI_DATA.
- iVld  input  1  upstream beat valid.
- oRdy  output  1  upstream ready; registered, with no combinational path from iRdy.
- iDat  input  WIDTH  upstream data.
- oVld  output  1  downstream beat valid.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH  downstream data; the main register.
- oCnt  output  2  occupancy, 0..2.

Behaviour:
- Storage: main register (drives oDat), skid register, state EMPTY/ONE/FULL.
- Outputs are decoded from state:
  - oVld = (state != EMPTY).
  - oRdy = (state != FULL).
  - oCnt = 0/1/2 for EMPTY/ONE/FULL.
- Transfer definitions: upstream transfer when iVld & oRdy; downstream transfer when oVld & iRdy.
- Priority per edge: rst low > iClr high > normal transitions.
- Reset (rst==0 at an edge):
  - state=EMPTY, main=skid=INI_DATA.
  - Outputs after the edge: oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA.
  - Reset mid-transfer drops both buffered beats with no further output.
- Flush (rst==1, iClr==1):
  - Same register result as reset.
  - Any upstream or downstream transfer in that cycle is void; the upstream beat is discarded.
- EMPTY:
  - iVld → main<=iDat, go to ONE.
  - Otherwise hold. iRdy is ignored.
- ONE:
  - up & down → main<=iDat, stay ONE (full throughput, one beat per cycle).
  - up only → skid<=iDat, go to FULL.
  - down only → go to EMPTY; main keeps its stale value.
  - Neither → hold.
- FULL:
  - oRdy=0, so iVld is ignored and iDat is not sampled.
  - iRdy → main<=skid, go to ONE.
  - Skid keeps its stale value.
- Ordering and loss:
  - Strict FIFO order.
  - No beat is lost or duplicated except through rst/iClr.
- Latency:
  - Beat accepted at edge N appears on oDat/oVld after edge N when the buffer is empty.
  - Throughput is 1 beat/cycle in steady state.
- Stall rule: while oVld==1 and iRdy==0, oDat and oVld are held stable.
- Data when empty: oDat is don't-care for the consumer when oVld==0, but must equal the last main value (no X after reset).
- Width: no arithmetic; data passes through bit-exact; oCnt never exceeds 2.

Test Plan:
- Reset, then flush:
  - rst=0 for 2 cycles with INI_DATA=32'h1 → oVld=0, oRdy=1, oCnt=0, oDat=32'h1.
  - Fill 2 beats, then iClr=1 for one cycle → same values next cycle.
- Streaming:
  - iRdy=1 constant; iVld=1 with iDat=32'hA0..32'hA7 on consecutive cycles.
  - → oDat shows A0..A7 in order, one cycle after acceptance; oRdy stays 1; oCnt stays 1.
- Backpressure fill:
  - iRdy=0; send 32'hB0, B1, B2.
  - → oCnt goes 1 then 2; oRdy=0 after B1; B2 is held upstream; oDat stays B0.
  - Then iRdy=1 → output order B0, B1, B2.
- Random stress:
  - 2000 cycles of random iVld/iRdy/iDat with iClr at 2% probability.
  - Scoreboard queue flushed on iClr → zero mismatches.
  - Also check: oDat stable whenever oVld&!iRdy; oRdy never asserted when oCnt==2.
- Flush with simultaneous handshakes:
  - In state ONE with iVld=iRdy=1, iDat=32'hC5, iClr=1 → next cycle oVld=0, oCnt=0, oDat=INI_DATA.
  - 32'hC5 never appears at the output.
- Reset mid-transfer:
  - In state FULL, assert rst=0 together with iRdy=1 → next cycle oCnt=0.
  - The skid beat is never emitted; after release, a new beat 32'hD1 passes with 1-cycle latency.
